// File: rtl/ldb_pkg.sv
// Shared LDB definitions: read-sequencer state encoding and request sizing.
// Pure declarations; no clocked logic, no handshakes.
package ldb_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CALC  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } ldb_seq_state_t;

    localparam int LDB_BOUNDARY_BYTES = 4096;
    localparam int LDB_REQ_LEN_W      = 9;

endpackage

// File: rtl/ldb_burst_len_calc.sv
// Combinational burst length: min(remaining, MAX_LEN, beats left to the next boundary).
// Zero latency, no handshake; the caller registers the result.
module ldb_burst_len_calc
    import ldb_pkg::*;
#(
    parameter int TOTAL_W  = 20,
    parameter int MAX_LEN  = 255,
    parameter int BOUNDARY = LDB_BOUNDARY_BYTES,
    parameter int ADDR_LSB = 4,
    parameter int BND_LOG  = $clog2(BOUNDARY)
) (
    input  logic [TOTAL_W-1:0]       remaining_i,
    input  logic [BND_LOG-1:0]       addr_lo_i,
    output logic [LDB_REQ_LEN_W-1:0] len_o
);

    logic [31:0] to_bnd;
    logic [31:0] rem_w;
    logic [31:0] cand;

    // Compare in a common 32-bit domain so every operand is zero-extended alike.
    always_comb begin
        to_bnd = (32'(BOUNDARY) - 32'(addr_lo_i)) >> ADDR_LSB;
        rem_w  = 32'(remaining_i);
        cand   = 32'(MAX_LEN);
        if (rem_w < cand) begin
            cand = rem_w;
        end
        if (to_bnd < cand) begin
            cand = to_bnd;
        end
        len_o = LDB_REQ_LEN_W'(cand);
    end

endmodule

// File: rtl/ldb_read_sequencer.sv
// Splits one large read command into boundary-safe bursts, one outstanding at a time.
// Accept->first req_valid 2 cycles; req_valid held until req_ready; cmd_ready only when idle.
module ldb_read_sequencer
    import ldb_pkg::*;
#(
    parameter int AXI_ADDR_W = 64,
    parameter int AXI_DATA_W = 128,
    parameter int MAX_LEN    = 255,
    parameter int TOTAL_W    = 20,
    parameter int BOUNDARY   = LDB_BOUNDARY_BYTES
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [AXI_ADDR_W-1:0]    cmd_addr,
    input  logic [TOTAL_W-1:0]       cmd_beats,
    output logic                     cmd_done,
    output logic                     cmd_err,
    output logic [15:0]              cmd_bursts,
    output logic                     req_valid,
    input  logic                     req_ready,
    output logic [AXI_ADDR_W-1:0]    req_addr,
    output logic [LDB_REQ_LEN_W-1:0] req_len,
    input  logic                     req_done,
    input  logic                     req_err
);

    localparam int DATA_BYTES = AXI_DATA_W / 8;
    localparam int ADDR_LSB   = $clog2(DATA_BYTES);
    localparam int BND_LOG    = $clog2(BOUNDARY);

    ldb_seq_state_t            state_q, state_d;
    logic [AXI_ADDR_W-1:0]     addr_q, addr_d;
    logic [TOTAL_W-1:0]        rem_q, rem_d;
    logic [LDB_REQ_LEN_W-1:0]  len_q, len_d;
    logic                      err_q, err_d;
    logic [15:0]               bursts_q, bursts_d;
    logic                      req_valid_q;
    logic                      cmd_done_q;
    logic                      cmd_err_q;
    logic [LDB_REQ_LEN_W-1:0]  calc_len;

    ldb_burst_len_calc #(
        .TOTAL_W  (TOTAL_W),
        .MAX_LEN  (MAX_LEN),
        .BOUNDARY (BOUNDARY),
        .ADDR_LSB (ADDR_LSB),
        .BND_LOG  (BND_LOG)
    ) u_len_calc (
        .remaining_i (rem_q),
        .addr_lo_i   (addr_q[BND_LOG-1:0]),
        .len_o       (calc_len)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        len_d    = len_q;
        err_d    = err_q;
        bursts_d = bursts_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    addr_d   = cmd_addr;
                    rem_d    = cmd_beats;
                    err_d    = 1'b0;
                    bursts_d = 16'd0;
                    // Zero-length or beat-unaligned commands complete immediately with an error.
                    if ((cmd_beats == '0) || (cmd_addr[ADDR_LSB-1:0] != '0)) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                len_d   = calc_len;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (req_ready) begin
                    addr_d  = addr_q + (AXI_ADDR_W'(len_q) << ADDR_LSB);
                    rem_d   = rem_q - TOTAL_W'(len_q);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (req_done) begin
                    if (bursts_q != 16'hFFFF) begin
                        bursts_d = bursts_q + 16'd1;
                    end
                    err_d = err_q | req_err;
                    // First errored burst ends the command; nothing further is issued.
                    if (req_err || (rem_q == '0)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            len_q       <= '0;
            err_q       <= 1'b0;
            bursts_q    <= 16'd0;
            req_valid_q <= 1'b0;
            cmd_done_q  <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            len_q       <= len_d;
            err_q       <= err_d;
            bursts_q    <= bursts_d;
            req_valid_q <= (state_d == S_ISSUE);
            cmd_done_q  <= (state_d == S_DONE);
            cmd_err_q   <= (state_d == S_DONE) && err_d;
        end
    end

    assign cmd_ready  = (state_q == S_IDLE);
    assign cmd_done   = cmd_done_q;
    assign cmd_err    = cmd_err_q;
    assign cmd_bursts = bursts_q;
    assign req_valid  = req_valid_q;
    assign req_addr   = addr_q;
    assign req_len    = len_q;

endmodule

// File: tb/tb_ldb_read_sequencer.sv
// Scoreboard bench for ldb_read_sequencer: directed commands, a read-master responder, and a monitor.
// Expected requests/completions are queued at stimulus time and popped when the DUT presents them.
module tb_ldb_read_sequencer;

    typedef struct {
        logic [63:0] addr;
        int          len;
    } exp_req_t;

    typedef struct {
        logic        err;
        int          bursts;
        logic        after_burst;
    } exp_cmp_t;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [63:0] cmd_addr;
    logic [19:0] cmd_beats;
    logic        cmd_done;
    logic        cmd_err;
    logic [15:0] cmd_bursts;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic [8:0]  req_len;
    logic        req_done;
    logic        req_err;

    int vectors     = 0;
    int miscompares = 0;

    exp_req_t exp_req[$];
    exp_cmp_t exp_cmp[$];

    int   hs_count   = 0;
    int   hs_handled = 0;
    int   err_at_hs  = -1;
    int   stall_left = 0;
    int   done_wait  = 0;
    logic pend_err   = 1'b0;
    logic glitch_err = 1'b0;
    logic forbid_req = 1'b0;

    ldb_read_sequencer #(
        .AXI_ADDR_W (64),
        .AXI_DATA_W (128),
        .MAX_LEN    (255),
        .TOTAL_W    (20),
        .BOUNDARY   (4096)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_beats  (cmd_beats),
        .cmd_done   (cmd_done),
        .cmd_err    (cmd_err),
        .cmd_bursts (cmd_bursts),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .req_done   (req_done),
        .req_err    (req_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_req(input logic [63:0] a, input int l);
        exp_req_t e;
        e.addr = a;
        e.len  = l;
        exp_req.push_back(e);
    endtask

    task automatic push_cmp(input logic e, input int b, input logic ab);
        exp_cmp_t c;
        c.err         = e;
        c.bursts      = b;
        c.after_burst = ab;
        exp_cmp.push_back(c);
    endtask

    // Offer a command at a negedge once cmd_ready is up; returns #1 after the accepting edge.
    task automatic send_cmd(input logic [63:0] a, input logic [19:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_timeout", {63'd0, cmd_ready}, 64'd1);
        cmd_addr  = a;
        cmd_beats = b;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_req.size() != 0 || exp_cmp.size() != 0 || !cmd_ready) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", {63'd0, (n >= 3000)}, 64'd0);
        @(negedge clk);
    endtask

    // Read-master model: accepts per stall_left, answers each burst 3 cycles after handshake.
    initial begin
        req_ready = 1'b0;
        req_done  = 1'b0;
        req_err   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            req_done = 1'b0;
            req_err  = glitch_err;
            if (rst) begin
                done_wait  = 0;
                hs_handled = hs_count;
                req_ready  = 1'b0;
                req_err    = 1'b0;
            end else begin
                if (hs_count != hs_handled) begin
                    hs_handled = hs_count;
                    done_wait  = 3;
                    pend_err   = (hs_handled == err_at_hs);
                end else if (done_wait > 0) begin
                    done_wait--;
                    if (done_wait == 0) begin
                        req_done = 1'b1;
                        req_err  = pend_err;
                    end
                end
                req_ready = (stall_left == 0);
                if (req_valid && stall_left > 0) stall_left--;
            end
        end
    end

    // Monitor: pops expectations on request handshakes and completions.
    initial begin
        logic        stall_prev;
        logic [63:0] prev_addr;
        logic [8:0]  prev_len;
        logic        prev_done;
        exp_req_t    e;
        exp_cmp_t    c;
        stall_prev = 1'b0;
        prev_addr  = '0;
        prev_len   = '0;
        prev_done  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
                prev_done  = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("stall_req_valid", {63'd0, req_valid}, 64'd1);
                    check("stall_req_addr", req_addr, prev_addr);
                    check("stall_req_len", {55'd0, req_len}, {55'd0, prev_len});
                end
                if (forbid_req) check("no_req_on_reject", {63'd0, req_valid}, 64'd0);
                if (req_valid && req_ready) begin
                    hs_count++;
                    if (exp_req.size() == 0) begin
                        check("unexpected_req", 64'd1, 64'd0);
                    end else begin
                        e = exp_req.pop_front();
                        check("req_addr", req_addr, e.addr);
                        check("req_len", {55'd0, req_len}, 64'(e.len));
                    end
                end
                if (cmd_done) begin
                    if (exp_cmp.size() == 0) begin
                        check("unexpected_cmd_done", 64'd1, 64'd0);
                    end else begin
                        c = exp_cmp.pop_front();
                        check("cmd_err", {63'd0, cmd_err}, {63'd0, c.err});
                        check("cmd_bursts", {48'd0, cmd_bursts}, 64'(c.bursts));
                        if (c.after_burst) check("done_after_req_done", {63'd0, prev_done}, 64'd1);
                    end
                end
                stall_prev = req_valid && !req_ready;
                prev_addr  = req_addr;
                prev_len   = req_len;
                prev_done  = req_done;
            end
        end
    end

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_beats = '0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_cmd_done", {63'd0, cmd_done}, 64'd0);
        check("rst_cmd_err", {63'd0, cmd_err}, 64'd0);
        check("rst_cmd_bursts", {48'd0, cmd_bursts}, 64'd0);
        check("rst_req_valid", {63'd0, req_valid}, 64'd0);
        check("rst_req_addr", req_addr, 64'd0);
        check("rst_req_len", {55'd0, req_len}, 64'd0);
        check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);

        // Single burst, also checks the accept->req_valid latency.
        push_req(64'h1000, 16);
        push_cmp(1'b0, 1, 1'b1);
        send_cmd(64'h1000, 20'd16);
        check("lat_calc_cycle_no_valid", {63'd0, req_valid}, 64'd0);
        @(posedge clk);
        #1;
        check("lat_req_valid_at_T2", {63'd0, req_valid}, 64'd1);
        wait_idle();

        // Long command split by MAX_LEN and the 4 KiB boundary.
        push_req(64'h0, 255);
        push_req(64'hFF0, 1);
        push_req(64'h1000, 255);
        push_req(64'h1FF0, 1);
        push_req(64'h2000, 88);
        push_cmp(1'b0, 5, 1'b1);
        send_cmd(64'h0, 20'd600);
        wait_idle();
        repeat (3) @(negedge clk);
        check("bursts_held_idle", {48'd0, cmd_bursts}, 64'd5);

        // Stalled first request plus stray req_err pulses that must be ignored.
        stall_left = 5;
        glitch_err = 1'b1;
        push_req(64'hF80, 8);
        push_req(64'h1000, 12);
        push_cmp(1'b0, 2, 1'b1);
        send_cmd(64'hF80, 20'd20);
        wait_idle();
        glitch_err = 1'b0;

        // Rejected commands: zero beats, then unaligned address.
        forbid_req = 1'b1;
        push_cmp(1'b1, 0, 1'b0);
        send_cmd(64'h2000, 20'd0);
        check("rej0_done_T1", {63'd0, cmd_done}, 64'd1);
        check("rej0_err_T1", {63'd0, cmd_err}, 64'd1);
        wait_idle();
        push_cmp(1'b1, 0, 1'b0);
        send_cmd(64'h1004, 20'd4);
        check("rejA_done_T1", {63'd0, cmd_done}, 64'd1);
        check("rejA_err_T1", {63'd0, cmd_err}, 64'd1);
        wait_idle();
        repeat (4) @(negedge clk);
        forbid_req = 1'b0;

        // Error on the second burst stops the command.
        err_at_hs = hs_count + 2;
        push_req(64'h0, 255);
        push_req(64'hFF0, 1);
        push_cmp(1'b1, 2, 1'b1);
        send_cmd(64'h0, 20'd600);
        wait_idle();
        repeat (10) @(negedge clk);
        check("no_third_req", {63'd0, req_valid}, 64'd0);
        err_at_hs = -1;

        // Reset while waiting for req_done, then a normal command.
        begin
            int base;
            int n;
            base = hs_count;
            n    = 0;
            push_req(64'h0, 255);
            send_cmd(64'h0, 20'd600);
            while (hs_count == base && n < 100) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("wait_handshake_timeout", {63'd0, (n >= 100)}, 64'd0);
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check("mid_rst_req_valid", {63'd0, req_valid}, 64'd0);
            check("mid_rst_cmd_done", {63'd0, cmd_done}, 64'd0);
            check("mid_rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
            check("mid_rst_req_drained", 64'(exp_req.size()), 64'd0);
            exp_req.delete();
            exp_cmp.delete();
        end
        push_req(64'h3000, 32);
        push_cmp(1'b0, 1, 1'b1);
        send_cmd(64'h3000, 20'd32);
        wait_idle();

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
